// File: rtl/dmem_sched.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sched
// Function : Serializes a dual-issue MEM-stage bundle (slot 1 first) onto the
//            single data-RAM request/addr_ok/data_ok port; stalls until done.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sched (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i1_valid,
    input  logic        i1_we,
    input  logic [3:0]  i1_bsel,
    input  logic [31:0] i1_addr,
    input  logic [31:0] i1_wdata,
    input  logic        i2_valid,
    input  logic        i2_we,
    input  logic [3:0]  i2_bsel,
    input  logic [31:0] i2_addr,
    input  logic [31:0] i2_wdata,
    input  logic        flush,
    output logic        dram_req,
    output logic        dram_wr,
    output logic [3:0]  dram_be,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic        dram_addr_ok,
    input  logic        dram_data_ok,
    input  logic [31:0] dram_rdata,
    output logic        stall_o,
    output logic [31:0] i1_rdata_o,
    output logic [31:0] i2_rdata_o,
    output logic        rdata_valid_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    state_t      r_state;

    logic        r_h1_we;
    logic [3:0]  r_h1_bsel;
    logic [31:0] r_h1_addr;
    logic [31:0] r_h1_wdata;
    logic        r_h2_valid;
    logic        r_h2_we;
    logic [3:0]  r_h2_bsel;
    logic [31:0] r_h2_addr;
    logic [31:0] r_h2_wdata;
    logic [31:0] r_i1_rdata;
    logic [31:0] r_i2_rdata;

    logic        w_req;
    logic        w_sel2;
    logic        w_busy;
    logic        w_take;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state    <= IDLE;
            r_h1_we    <= 1'b0;
            r_h1_bsel  <= 4'd0;
            r_h1_addr  <= 32'd0;
            r_h1_wdata <= 32'd0;
            r_h2_valid <= 1'b0;
            r_h2_we    <= 1'b0;
            r_h2_bsel  <= 4'd0;
            r_h2_addr  <= 32'd0;
            r_h2_wdata <= 32'd0;
            r_i1_rdata <= 32'd0;
            r_i2_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((i1_valid | i2_valid) & ~flush) begin
                        r_h1_we    <= i1_we;
                        r_h1_bsel  <= i1_bsel;
                        r_h1_addr  <= i1_addr;
                        r_h1_wdata <= i1_wdata;
                        r_h2_valid <= i2_valid;
                        r_h2_we    <= i2_we;
                        r_h2_bsel  <= i2_bsel;
                        r_h2_addr  <= i2_addr;
                        r_h2_wdata <= i2_wdata;
                        r_state    <= i1_valid ? REQ1 : REQ2;
                    end
                end
                // An accepted request must still be drained even if flushed.
                REQ1: begin
                    if (dram_addr_ok)
                        r_state <= flush ? DRAIN : WAIT1;
                    else if (flush)
                        r_state <= IDLE;
                end
                WAIT1: begin
                    if (dram_data_ok) begin
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            if (!r_h1_we)
                                r_i1_rdata <= dram_rdata;
                            r_state <= r_h2_valid ? REQ2 : DONE;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                REQ2: begin
                    if (dram_addr_ok)
                        r_state <= flush ? DRAIN : WAIT2;
                    else if (flush)
                        r_state <= IDLE;
                end
                WAIT2: begin
                    if (dram_data_ok) begin
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            if (!r_h2_we)
                                r_i2_rdata <= dram_rdata;
                            r_state <= DONE;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DONE: r_state <= IDLE;
                DRAIN: begin
                    if (dram_data_ok)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_req  = (r_state == REQ1) || (r_state == REQ2);
    assign w_sel2 = (r_state == REQ2);

    assign dram_req   = w_req;
    assign dram_wr    = w_req & (w_sel2 ? r_h2_we : r_h1_we);
    assign dram_be    = w_req ? (w_sel2 ? r_h2_bsel  : r_h1_bsel)  : 4'd0;
    assign dram_addr  = w_req ? (w_sel2 ? r_h2_addr  : r_h1_addr)  : 32'd0;
    assign dram_wdata = w_req ? (w_sel2 ? r_h2_wdata : r_h1_wdata) : 32'd0;

    assign w_busy = (r_state == REQ1) || (r_state == WAIT1) || (r_state == REQ2) ||
                    (r_state == WAIT2) || (r_state == DRAIN);
    assign w_take = (r_state == IDLE) && (i1_valid || i2_valid) && !flush;

    // Inputs can make stall_o high in IDLE, so mask it during reset.
    assign stall_o       = ~resetn & (w_busy | w_take);
    assign i1_rdata_o    = r_i1_rdata;
    assign i2_rdata_o    = r_i2_rdata;
    assign rdata_valid_o = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sched
// Function : Self-checking bench for dmem_sched: transaction-level model,
//            randomized RAM latencies/flushes, plus directed literal cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        i1_valid = 1'b0, i1_we = 1'b0;
    logic [3:0]  i1_bsel = 4'd0;
    logic [31:0] i1_addr = 32'd0, i1_wdata = 32'd0;
    logic        i2_valid = 1'b0, i2_we = 1'b0;
    logic [3:0]  i2_bsel = 4'd0;
    logic [31:0] i2_addr = 32'd0, i2_wdata = 32'd0;
    logic        flush = 1'b0;
    logic        dram_req, dram_wr;
    logic [3:0]  dram_be;
    logic [31:0] dram_addr, dram_wdata;
    logic        dram_addr_ok = 1'b0, dram_data_ok = 1'b0;
    logic [31:0] dram_rdata = 32'd0;
    logic        stall_o, rdata_valid_o;
    logic [31:0] i1_rdata_o, i2_rdata_o;

    dmem_sched dut (
        .clk(clk), .resetn(resetn),
        .i1_valid(i1_valid), .i1_we(i1_we), .i1_bsel(i1_bsel), .i1_addr(i1_addr), .i1_wdata(i1_wdata),
        .i2_valid(i2_valid), .i2_we(i2_we), .i2_bsel(i2_bsel), .i2_addr(i2_addr), .i2_wdata(i2_wdata),
        .flush(flush),
        .dram_req(dram_req), .dram_wr(dram_wr), .dram_be(dram_be), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_addr_ok(dram_addr_ok), .dram_data_ok(dram_data_ok),
        .dram_rdata(dram_rdata), .stall_o(stall_o), .i1_rdata_o(i1_rdata_o),
        .i2_rdata_o(i2_rdata_o), .rdata_valid_o(rdata_valid_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM responder ----------------
    int          alat_q[$];
    int          dlat_q[$];
    logic [31:0] rd_q[$];
    int          acnt = 0, dcnt = 0;
    bit          pend = 0, aload = 0;

    always begin
        @(posedge clk);
        #2;
        if (resetn) begin
            pend = 0; aload = 0;
            dram_addr_ok = 1'b0; dram_data_ok = 1'b0;
            alat_q.delete(); dlat_q.delete(); rd_q.delete();
        end else begin
            if (dram_data_ok) pend = 0;
            if (dram_addr_ok) begin
                pend  = 1;
                aload = 0;
                dcnt  = (dlat_q.size() > 0) ? dlat_q.pop_front() : int'($urandom_range(0, 3));
            end
            dram_addr_ok = 1'b0;
            dram_data_ok = 1'b0;
            if (pend) begin
                if (dcnt == 0) begin
                    dram_data_ok = 1'b1;
                    dram_rdata   = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom();
                end else begin
                    dcnt--;
                end
            end else if (dram_req) begin
                if (!aload) begin
                    aload = 1;
                    acnt  = (alat_q.size() > 0) ? alat_q.pop_front() : int'($urandom_range(0, 3));
                end
                if (acnt == 0) dram_addr_ok = 1'b1;
                else acnt--;
            end else begin
                aload = 0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        slot2;
    } op_t;

    op_t         mq[$];         // ops of the live bundle not yet requested
    bit          m_out = 0;     // a response is owed by the RAM
    bit          m_out_slot2 = 0, m_out_wr = 0, m_disc = 0;
    bit          m_done = 0;    // bundle-complete cycle
    logic [31:0] m_r1 = 32'd0, m_r2 = 32'd0;
    bit          m_busy, m_req;
    op_t         m_op;

    always @(negedge clk) begin
        if (resetn) begin
            chk("rst_req", dram_req, 0);
            chk("rst_stall", stall_o, 0);
            chk("rst_valid", rdata_valid_o, 0);
            chk("rst_r1", i1_rdata_o, 0);
            chk("rst_r2", i2_rdata_o, 0);
            mq.delete();
            m_out = 0; m_disc = 0; m_done = 0;
            m_r1 = 32'd0; m_r2 = 32'd0;
        end else begin
            m_busy = (mq.size() > 0) || m_out;
            m_req  = (mq.size() > 0) && !m_out;
            chk("req", dram_req, m_req);
            chk("stall", stall_o, m_busy || (!m_done && (i1_valid || i2_valid) && !flush));
            chk("rdata_valid", rdata_valid_o, m_done);
            chk("i1_rdata", i1_rdata_o, m_r1);
            chk("i2_rdata", i2_rdata_o, m_r2);
            if (m_req && dram_req) begin
                m_op = mq[0];
                chk("req_wr", dram_wr, m_op.wr);
                chk("req_be", dram_be, m_op.be);
                chk("req_addr", dram_addr, m_op.addr);
                chk("req_wdata", dram_wdata, m_op.wdata);
            end
            // advance to what the next rising edge must produce
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if ((i1_valid || i2_valid) && !flush) begin
                    if (i1_valid) mq.push_back({i1_addr, i1_wdata, i1_bsel, i1_we, 1'b0});
                    if (i2_valid) mq.push_back({i2_addr, i2_wdata, i2_bsel, i2_we, 1'b1});
                end
            end else if (!m_out) begin
                if (dram_addr_ok) begin
                    m_op        = mq.pop_front();
                    m_out       = 1;
                    m_out_slot2 = m_op.slot2;
                    m_out_wr    = m_op.wr;
                    m_disc      = flush;
                    if (flush) mq.delete();
                end else if (flush) begin
                    mq.delete();
                end
            end else begin
                if (dram_data_ok) begin
                    m_out = 0;
                    if (m_disc || flush) begin
                        mq.delete();
                    end else begin
                        if (!m_out_wr) begin
                            if (m_out_slot2) m_r2 = dram_rdata;
                            else m_r1 = dram_rdata;
                        end
                        if (mq.size() == 0) m_done = 1;
                    end
                end else if (flush) begin
                    m_disc = 1;
                    mq.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        tr_stall[16], tr_valid[16], tr_req[16], tr_wr[16];
    logic [3:0]  tr_be[16];
    logic [31:0] tr_addr[16], tr_wdata[16], tr_r1[16], tr_r2[16];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i1_valid = 1'b0; i2_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic drive(input logic v1, input logic we1, input logic [3:0] b1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic v2, input logic we2, input logic [3:0] b2,
                         input logic [31:0] a2, input logic [31:0] d2);
        i1_valid = v1; i1_we = we1; i1_bsel = b1; i1_addr = a1; i1_wdata = d1;
        i2_valid = v2; i2_we = we2; i2_bsel = b2; i2_addr = a2; i2_wdata = d2;
    endtask

    // Bundle is presented for c0 only; flush is pulsed at cycle flush_at.
    task automatic run_dir(input int ncyc, input int flush_at);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                next_cycle();
                clear_inputs();
                flush = (c == flush_at);
            end
            @(negedge clk);
            tr_stall[c] = stall_o;   tr_valid[c] = rdata_valid_o;
            tr_req[c]   = dram_req;  tr_wr[c]    = dram_wr;
            tr_be[c]    = dram_be;   tr_addr[c]  = dram_addr;
            tr_wdata[c] = dram_wdata;
            tr_r1[c]    = i1_rdata_o; tr_r2[c]   = i2_rdata_o;
        end
        next_cycle();
        clear_inputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        next_cycle();

        // single load, immediate RAM
        alat_q.push_back(0); dlat_q.push_back(0); rd_q.push_back(32'hDEADBEEF);
        drive(1, 0, 4'hF, 32'h1000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        run_dir(5, -1);
        chk("t1_stall_c0", tr_stall[0], 1);
        chk("t1_stall_c2", tr_stall[2], 1);
        chk("t1_stall_c3", tr_stall[3], 0);
        chk("t1_valid_c2", tr_valid[2], 0);
        chk("t1_valid_c3", tr_valid[3], 1);
        chk("t1_valid_c4", tr_valid[4], 0);
        chk("t1_addr_c1", tr_addr[1], 32'h1000);
        chk("t1_r1_c3", tr_r1[3], 32'hDEADBEEF);

        // store slot 1 then load slot 2
        alat_q.push_back(0); alat_q.push_back(0);
        dlat_q.push_back(0); dlat_q.push_back(0);
        rd_q.push_back(32'h55555555); rd_q.push_back(32'hCAFEF00D);
        drive(1, 1, 4'b0011, 32'h2000, 32'h11223344, 1, 0, 4'hF, 32'h2004, 32'h0);
        run_dir(7, -1);
        chk("t2_req1_wr", tr_wr[1], 1);
        chk("t2_req1_be", tr_be[1], 4'b0011);
        chk("t2_req1_addr", tr_addr[1], 32'h2000);
        chk("t2_req1_wdata", tr_wdata[1], 32'h11223344);
        chk("t2_req_c2", tr_req[2], 0);
        chk("t2_req2_wr", tr_wr[3], 0);
        chk("t2_req2_addr", tr_addr[3], 32'h2004);
        chk("t2_stall_c4", tr_stall[4], 1);
        chk("t2_valid_c5", tr_valid[5], 1);
        chk("t2_r1_c5", tr_r1[5], 32'hDEADBEEF);
        chk("t2_r2_c5", tr_r2[5], 32'hCAFEF00D);

        // addr_ok withheld 3 cycles
        alat_q.push_back(3); dlat_q.push_back(0); rd_q.push_back(32'h33330003);
        drive(1, 0, 4'hF, 32'h3000, 32'h0BAD0BAD, 0, 0, 4'h0, 32'h0, 32'h0);
        run_dir(8, -1);
        for (int c = 1; c <= 4; c++) begin
            chk("t3_req_hold", tr_req[c], 1);
            chk("t3_addr_hold", tr_addr[c], 32'h3000);
            chk("t3_wdata_hold", tr_wdata[c], 32'h0BAD0BAD);
        end
        chk("t3_valid_c3", tr_valid[3], 0);
        chk("t3_valid_c6", tr_valid[6], 1);
        chk("t3_r1_c6", tr_r1[6], 32'h33330003);

        // flush in WAIT1, data_ok two cycles later
        alat_q.push_back(0); dlat_q.push_back(2); rd_q.push_back(32'h44444444);
        drive(1, 0, 4'hF, 32'h4000, 32'h0, 1, 0, 4'hF, 32'h4004, 32'h0);
        run_dir(7, 2);
        chk("t4_stall_c3", tr_stall[3], 1);
        chk("t4_stall_c4", tr_stall[4], 1);
        chk("t4_stall_c5", tr_stall[5], 0);
        chk("t4_noreq2_c3", tr_req[3], 0);
        chk("t4_noreq2_c5", tr_req[5], 0);
        chk("t4_valid_c5", tr_valid[5], 0);
        chk("t4_r1_c6", tr_r1[6], 32'h33330003);

        // flush together with addr_ok in REQ1
        alat_q.push_back(0); dlat_q.push_back(0); rd_q.push_back(32'h55550005);
        drive(1, 0, 4'hF, 32'h5000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        run_dir(5, 1);
        chk("t5a_stall_drain", tr_stall[2], 1);
        chk("t5a_stall_c3", tr_stall[3], 0);
        chk("t5a_valid_c2", tr_valid[2], 0);
        chk("t5a_r1_c4", tr_r1[4], 32'h33330003);

        // flush in REQ2 while addr_ok is withheld
        alat_q.push_back(0); alat_q.push_back(5);
        dlat_q.push_back(0); rd_q.push_back(32'h600D0001);
        drive(1, 0, 4'hF, 32'h6000, 32'h0, 1, 0, 4'hF, 32'h6004, 32'h0);
        run_dir(6, 3);
        chk("t5b_req_c3", tr_req[3], 1);
        chk("t5b_addr_c3", tr_addr[3], 32'h6004);
        chk("t5b_req_c4", tr_req[4], 0);
        chk("t5b_stall_c4", tr_stall[4], 0);
        chk("t5b_r1_c4", tr_r1[4], 32'h600D0001);

        // asynchronous reset during WAIT2
        alat_q.push_back(0); alat_q.push_back(0);
        dlat_q.push_back(0); dlat_q.push_back(3);
        rd_q.push_back(32'h70000001);
        drive(1, 0, 4'hF, 32'h7000, 32'h0, 1, 0, 4'hF, 32'h7004, 32'h0);
        run_dir(4, -1);
        chk("t6_r1_c3", tr_r1[3], 32'h70000001);
        chk("t6_req2_c3", tr_addr[3], 32'h7004);
        #3 resetn = 1'b1;
        #1;
        chk("t6_async_stall", stall_o, 0);
        chk("t6_async_req", dram_req, 0);
        chk("t6_async_addr", dram_addr, 0);
        chk("t6_async_r1", i1_rdata_o, 0);
        chk("t6_async_valid", rdata_valid_o, 0);
        repeat (2) next_cycle();
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_post_stall", stall_o, 0);
        chk("t6_post_req", dram_req, 0);
        next_cycle();

        // randomized bundles, latencies and flushes
        for (int b = 0; b < 300; b++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 4'($urandom()),
                  $urandom() & 32'hFFFF_FFFC, $urandom(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1), 4'($urandom()),
                  $urandom() & 32'hFFFF_FFFC, $urandom());
            flush = ($urandom_range(0, 19) == 0);
            cyc = 0;
            forever begin
                @(negedge clk);
                if (!stall_o) break;
                cyc++;
                if (cyc > 60) begin
                    chk("rand_timeout", 1, 0);
                    break;
                end
                next_cycle();
                clear_inputs();
                flush = ($urandom_range(0, 9) == 0);
            end
            next_cycle();
            clear_inputs();
        end

        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
